// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the SAP-1.5 control unit: opcode encoding and the
// per-cycle control word that fans out to every datapath strobe.
package cpu_ctrl_pkg;

  localparam int unsigned OPCODE_W    = 4;
  localparam int unsigned STEP_W      = 3;
  localparam int unsigned FETCH_STEPS = 2;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_LDB = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_STA = 4'h5,
    OP_LDI = 4'h6,
    OP_JMP = 4'h7,
    OP_JC  = 4'h8,
    OP_JZ  = 4'h9,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_load;
    logic pc_oe;
    logic mar_load;
    logic ram_oe;
    logic ram_we;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic alu_sub;
    logic alu_oe;
    logic flags_load;
    logic out_load;
  } ctrl_word_t;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: (opcode, T-state, flags) -> control word,
// plus end-of-instruction and halt indications.
module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = 3
) (
  input  logic [3:0]        opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              flag_zero,
  input  logic              flag_carry,
  output ctrl_word_t        cw,
  output logic              last,
  output logic              hlt
);

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(FETCH_STEPS);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(FETCH_STEPS + 1);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(FETCH_STEPS + 2);

  opcode_t op;
  assign op = opcode_t'(opcode);

  // Decode one microstep; unreachable steps end the instruction so a stray
  // step value always falls back to fetch.
  always_comb begin
    cw   = '0;
    last = 1'b0;
    hlt  = 1'b0;
    case (step)
      T0: begin
        cw.pc_oe    = 1'b1;
        cw.mar_load = 1'b1;
      end
      T1: begin
        cw.ram_oe  = 1'b1;
        cw.ir_load = 1'b1;
        cw.pc_inc  = 1'b1;
      end
      T2: begin
        case (op)
          OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: begin
            cw.ir_oe    = 1'b1;
            cw.mar_load = 1'b1;
          end
          OP_LDI: begin
            cw.ir_oe  = 1'b1;
            cw.a_load = 1'b1;
            last      = 1'b1;
          end
          OP_JMP: begin
            cw.ir_oe   = 1'b1;
            cw.pc_load = 1'b1;
            last       = 1'b1;
          end
          OP_JC: begin
            cw.ir_oe   = flag_carry;
            cw.pc_load = flag_carry;
            last       = 1'b1;
          end
          OP_JZ: begin
            cw.ir_oe   = flag_zero;
            cw.pc_load = flag_zero;
            last       = 1'b1;
          end
          OP_OUT: begin
            cw.a_oe     = 1'b1;
            cw.out_load = 1'b1;
            last        = 1'b1;
          end
          OP_HLT:  hlt  = 1'b1;
          default: last = 1'b1;
        endcase
      end
      T3: begin
        case (op)
          OP_LDA: begin
            cw.ram_oe = 1'b1;
            cw.a_load = 1'b1;
            last      = 1'b1;
          end
          OP_LDB: begin
            cw.ram_oe = 1'b1;
            cw.b_load = 1'b1;
            last      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw.ram_oe = 1'b1;
            cw.b_load = 1'b1;
          end
          OP_STA: begin
            cw.a_oe   = 1'b1;
            cw.ram_we = 1'b1;
            last      = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      T4: begin
        case (op)
          OP_ADD, OP_SUB: begin
            cw.alu_oe     = 1'b1;
            cw.a_load     = 1'b1;
            cw.flags_load = 1'b1;
            cw.alu_sub    = (op == OP_SUB);
            last          = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// SAP-1.5 control unit: T-state counter and halt latch around the microcode
// decode, with outputs forced low during reset and while halted.
module microcode_sequencer #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned STEP_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_zero,
  input  logic                flag_carry,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                pc_oe,
  output logic                mar_load,
  output logic                ram_oe,
  output logic                ram_we,
  output logic                ir_load,
  output logic                ir_oe,
  output logic                a_load,
  output logic                a_oe,
  output logic                b_load,
  output logic                alu_sub,
  output logic                alu_oe,
  output logic                flags_load,
  output logic                out_load,
  output logic                halted,
  output logic [STEP_W-1:0]   step
);

  logic [STEP_W-1:0]       step_q, step_d;
  logic                    halted_q, halted_d;
  cpu_ctrl_pkg::ctrl_word_t cw_rom, cw;
  logic                    last, hlt;

  microcode_rom #(
    .STEP_W (STEP_W)
  ) u_rom (
    .opcode     (opcode[3:0]),
    .step       (step_q),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .cw         (cw_rom),
    .last       (last),
    .hlt        (hlt)
  );

  // Next step/halt: freeze once halted, wrap to T0 after the last microstep.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (hlt) begin
        halted_d = 1'b1;
      end else if (last) begin
        step_d = '0;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Gate the control word so nothing strobes during reset or after halt.
  always_comb begin
    cw = cw_rom;
    if (reset || halted_q) cw = '0;
  end

  assign pc_inc     = cw.pc_inc;
  assign pc_load    = cw.pc_load;
  assign pc_oe      = cw.pc_oe;
  assign mar_load   = cw.mar_load;
  assign ram_oe     = cw.ram_oe;
  assign ram_we     = cw.ram_we;
  assign ir_load    = cw.ir_load;
  assign ir_oe      = cw.ir_oe;
  assign a_load     = cw.a_load;
  assign a_oe       = cw.a_oe;
  assign b_load     = cw.b_load;
  assign alu_sub    = cw.alu_sub;
  assign alu_oe     = cw.alu_oe;
  assign flags_load = cw.flags_load;
  assign out_load   = cw.out_load;
  assign halted     = halted_q;
  assign step       = step_q;

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Control unit for the SAP-1.5 8-bit computer.
- Steps a T-state counter and decodes (opcode, T-state, flags) into the per-cycle control word for the shared bus, PC, MAR, RAM, IR, A/B registers, ALU, flags and output register.
- Sits between the instruction register and every datapath load/output-enable strobe.
- Owns halt: `run_until_halt`-style benches observe its `halted` output.

Parameters:
- OPCODE_W, 4, width of the opcode field (IR upper nibble).
- STEP_W, 3, width of the T-state counter; at most 8 microsteps per instruction.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  OPCODE_W  IR[7:4]; valid from T2 onward.
- flag_zero  input  1  registered Z flag.
- flag_carry  input  1  registered C flag.
- pc_inc  output  1  increment PC.
- pc_load  output  1  load PC from bus.
- pc_oe  output  1  PC drives bus.
- mar_load  output  1  load MAR from bus low nibble.
- ram_oe  output  1  RAM[MAR] drives bus.
- ram_we  output  1  write bus into RAM[MAR].
- ir_load  output  1  load IR from bus.
- ir_oe  output  1  IR[3:0] drives bus, zero-extended.
- a_load  output  1  load A.
- a_oe  output  1  A drives bus.
- b_load  output  1  load B.
- alu_sub  output  1  ALU subtracts (else adds).
- alu_oe  output  1  ALU result drives bus.
- flags_load  output  1  latch Z/C from ALU.
- out_load  output  1  load output register.
- halted  output  1  CPU stopped.
- step  output  STEP_W  current T-state, for debug/bench.

Behaviour:
- State:
  - `step` register, reset to 0.
  - `halted` register, reset to 0.
- Reset:
  - While `reset` is high, every control output is 0, regardless of step.
  - On the first edge after deassertion, `step` = 0.
  - Reset mid-instruction (any step, or while halted) returns to T0 with `halted` = 0 on the next edge.
- Control word timing: combinational from (`step`, `opcode`, flags). Asserted for the whole cycle; consumers latch on the next rising edge.
- Fetch, common to all opcodes:
  - T0: `pc_oe`, `mar_load`.
  - T1: `ram_oe`, `ir_load`, `pc_inc`.
- Execute, by opcode (`last` = step returns to 0 on this edge):
  - NOP 0x0: T2 `last`.
  - LDA 0x1: T2 `ir_oe`, `mar_load`; T3 `ram_oe`, `a_load`, `last`.
  - LDB 0x2: T2 `ir_oe`, `mar_load`; T3 `ram_oe`, `b_load`, `last`.
  - ADD 0x3: T2 `ir_oe`, `mar_load`; T3 `ram_oe`, `b_load`; T4 `alu_oe`, `a_load`, `flags_load`, `last`.
  - SUB 0x4: same as ADD, with `alu_sub` = 1 in T4.
  - STA 0x5: T2 `ir_oe`, `mar_load`; T3 `a_oe`, `ram_we`, `last`.
  - LDI 0x6: T2 `ir_oe`, `a_load`, `last`.
  - JMP 0x7: T2 `ir_oe`, `pc_load`, `last`.
  - JC 0x8: T2 `ir_oe` and `pc_load` only if `flag_carry` = 1; `last` in either case.
  - JZ 0x9: as JC, using `flag_zero`.
  - OUT 0xE: T2 `a_oe`, `out_load`, `last`.
  - HLT 0xF: T2 no strobes; `halted` sets on this edge.
  - 0xA–0xD: treated as NOP.
- Step advance: `step` increments each edge unless the current step is `last` (then 0) or `halted` = 1 (frozen).
- Halt: once set, `halted` stays 1 until reset. All other strobes are 0 and `step` holds its value.
- Flags are sampled combinationally in T2 only. A flag change in other steps has no effect.
- The control word never asserts more than one bus driver (`*_oe`) in the same cycle.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - `opcode_t` enum (values above).
  - Packed `ctrl_word_t` struct with one bit per strobe.
  - `FETCH_STEPS` = 2.
  - `STEP_W`.
- Sub-module `microcode_rom`: purely combinational (`opcode`, `step`, `flag_zero`, `flag_carry`) → (`ctrl_word_t`, `last`, `hlt`).
- `microcode_sequencer` holds only the `step`/`halted` registers, reset gating, and unpacking of the control word onto ports.

Test Plan:
- Reset held 3 cycles, then released → during reset all strobes 0. First cycle after release: `step`=0, `pc_oe`=`mar_load`=1. Next cycle: `ram_oe`=`ir_load`=`pc_inc`=1.
- `opcode`=0x2 (LDB) → T2 `ir_oe`+`mar_load`; T3 `ram_oe`+`b_load`; then `step`=0. Total 4 cycles, `b_load` high exactly once.
- `opcode`=0x3 (ADD) → 5-cycle instruction, `alu_sub`=0. With 0x4 (SUB), `alu_sub`=1 and `flags_load`=1 in T4 only.
- `opcode`=0x8 (JC) with `flag_carry`=0 → `pc_load`=0, back to T0 after T2. With `flag_carry`=1 → `pc_load`=`ir_oe`=1 in T2. Repeat the pair for JZ with `flag_zero`.
- `opcode`=0xF (HLT) → `halted`=1 from the edge ending T2. Over the next 10 cycles `step` stays 2 and all strobes are 0. Reset pulse → `halted`=0, `step`=0.
- Reset asserted during T3 of ADD → no `a_load`/`flags_load` is ever issued for that instruction. Next cycle after release is T0 fetch.
